instruction_fetch_stage: RTL and testbench

Fetch stage of the RISC-V core, directly upstream of main_controller. It holds the program counter and addresses the synchronous instruction ROM. It also redirects on taken branches. It presents the fetched instruction, its PC and its 7-bit opcode in an IF/ID pipeline register; main_controller and the decoder read that register. Stall and flush inputs from the hazard logic freeze the stage or inject bubbles.

---
 rtl/instruction_fetch_stage.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the synchronous instruction
// ROM, redirects on taken branches and holds the IF/ID pipeline register.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   stall, flush          hazard controls (freeze stage / inject bubble)
//   branch_taken/_target  PC redirect request and byte target
//   imem_addr             combinational ROM word address
//   imem_rdata            ROM data, one cycle after imem_addr
//   if_id_pc/_instruction/_opcode/_valid  IF/ID pipeline register
//   fetch_count           number of valid instructions loaded into IF/ID
//   misalign_err          sticky flag for a branch target with bits [1:0] != 0
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned IMEM_ADDR_WIDTH = 10,
   parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       branch_taken,
   input  logic [31:0]                branch_target,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]                imem_rdata,
   output logic [31:0]                if_id_pc,
   output logic [31:0]                if_id_instruction,
   output logic [6:0]                 if_id_opcode,
   output logic                       if_id_valid,
   output logic [31:0]                fetch_count,
   output logic                       misalign_err
);

   localparam logic [6:0] NOP_OPCODE = 7'b0010011;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_f;
   logic [31:0] pc_sel;
   logic [31:0] tgt;
   logic        bubble_c;
   logic        load_c;
   logic        misalign_c;

   // FSM state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= BOOT;
      else       state <= state_next;
   end

   // FSM next state and per-cycle IF/ID decisions
   always_comb begin
      state_next = state;
      bubble_c   = 1'b0;
      load_c     = 1'b0;
      misalign_c = 1'b0;
      unique case (state)
         BOOT: state_next = RUN;
         RUN: begin
            state_next = RUN;
            bubble_c   = branch_taken | flush;
            load_c     = ~(branch_taken | flush) & ~stall;
            misalign_c = branch_taken & (branch_target[1:0] != 2'b00);
         end
         default: state_next = BOOT;
      endcase
   end

   // Next fetch PC: boot vector, branch target, hold, or sequential
   assign tgt = {branch_target[31:2], 2'b00};

   always_comb begin
      pc_sel = pc_f + 32'd4;
      if (state == BOOT)      pc_sel = RESET_PC;
      else if (branch_taken)  pc_sel = tgt;
      else if (stall)         pc_sel = pc_f;
   end

   // ROM is word addressed; upper PC bits alias
   assign imem_addr = pc_sel[IMEM_ADDR_WIDTH+1:2];

   // pc_f tracks the PC whose word is currently on imem_rdata
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) pc_f <= RESET_PC;
      else       pc_f <= pc_sel;
   end

   // IF/ID register: bubble beats stall, stall holds, otherwise load
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         if_id_pc          <= 32'd0;
         if_id_instruction <= NOP_INSTR;
         if_id_opcode      <= NOP_OPCODE;
         if_id_valid       <= 1'b0;
      end else if (bubble_c) begin
         if_id_pc          <= pc_f;
         if_id_instruction <= NOP_INSTR;
         if_id_opcode      <= NOP_OPCODE;
         if_id_valid       <= 1'b0;
      end else if (load_c) begin
         if_id_pc          <= pc_f;
         if_id_instruction <= imem_rdata;
         if_id_opcode      <= imem_rdata[6:0];
         if_id_valid       <= 1'b1;
      end
   end

   // Valid-load counter and sticky misalignment flag
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         fetch_count  <= 32'd0;
         misalign_err <= 1'b0;
      end else begin
         if (load_c)     fetch_count  <= fetch_count + 32'd1;
         if (misalign_c) misalign_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed vector table,
// mid-run reset sequence, then randomized traffic against a reference model.
module tb_instruction_fetch_stage;

   localparam int unsigned AW     = 10;
   localparam int unsigned DEPTH  = 1 << AW;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          stall, flush, branch_taken;
   logic [31:0]   branch_target;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic [31:0]   if_id_pc, if_id_instruction, fetch_count;
   logic [6:0]    if_id_opcode;
   logic          if_id_valid, misalign_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rom [DEPTH];

   instruction_fetch_stage #(
      .RESET_PC(RST_PC), .IMEM_ADDR_WIDTH(AW), .NOP_INSTR(NOP)
   ) dut (
      .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
      .if_id_opcode(if_id_opcode), .if_id_valid(if_id_valid),
      .fetch_count(fetch_count), .misalign_err(misalign_err)
   );

   always #5 CLK = ~CLK;

   // Synchronous ROM: one cycle read latency
   always @(posedge CLK) imem_rdata <= rom[imem_addr];

   // Reference model, tracked at the architectural level
   logic        m_boot, m_valid, m_mis;
   logic [31:0] m_pc_f, m_pc, m_instr, m_cnt;

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      return rom[pc[AW+1:2]];
   endfunction

   function automatic logic [31:0] model_next_pc(input logic s, input logic b,
                                                 input logic [31:0] t);
      if (m_boot) return RST_PC;
      if (b)      return t & 32'hFFFF_FFFC;
      if (s)      return m_pc_f;
      return m_pc_f + 32'd4;
   endfunction

   task automatic model_reset();
      m_boot = 1'b1; m_pc_f = RST_PC; m_valid = 1'b0; m_pc = 32'd0;
      m_instr = NOP; m_cnt = 32'd0; m_mis = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic f, input logic b,
                             input logic [31:0] t);
      logic [31:0] nxt;
      nxt = model_next_pc(s, b, t);
      if (!m_boot) begin
         if (b || f) begin
            m_valid = 1'b0; m_instr = NOP; m_pc = m_pc_f;
         end else if (!s) begin
            m_valid = 1'b1; m_instr = rom_word(m_pc_f); m_pc = m_pc_f;
            m_cnt = m_cnt + 32'd1;
         end
         if (b && t[1:0] != 2'b00) m_mis = 1'b1;
      end
      m_pc_f = nxt;
      m_boot = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, sample address, clock, sample IF/ID at negedge
   logic [AW-1:0] seen_addr, model_addr;
   task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t);
      logic [31:0] np;
      stall = s; flush = f; branch_taken = b; branch_target = t;
      #1;
      seen_addr  = imem_addr;
      np         = model_next_pc(s, b, t);
      model_addr = np[AW+1:2];
      @(posedge CLK);
      model_edge(s, f, b, t);
      @(negedge CLK);
   endtask

   task automatic check_model(input string tag);
      logic [31:0] oi;
      oi = m_instr;
      chk({tag, ".addr"},   32'(seen_addr), 32'(model_addr));
      chk({tag, ".valid"},  32'(if_id_valid), 32'(m_valid));
      chk({tag, ".pc"},     if_id_pc, m_pc);
      chk({tag, ".instr"},  if_id_instruction, m_instr);
      chk({tag, ".opcode"}, 32'(if_id_opcode), 32'(oi[6:0]));
      chk({tag, ".count"},  fetch_count, m_cnt);
      chk({tag, ".mis"},    32'(misalign_err), 32'(m_mis));
   endtask

   task automatic check_reset_vals(input string tag);
      logic [31:0] rp;
      rp = RST_PC;
      chk({tag, ".addr"},   32'(imem_addr), 32'(rp[AW+1:2]));
      chk({tag, ".valid"},  32'(if_id_valid), 32'd0);
      chk({tag, ".pc"},     if_id_pc, 32'd0);
      chk({tag, ".instr"},  if_id_instruction, NOP);
      chk({tag, ".opcode"}, 32'(if_id_opcode), 32'h13);
      chk({tag, ".count"},  fetch_count, 32'd0);
      chk({tag, ".mis"},    32'(misalign_err), 32'd0);
   endtask

   // Directed vectors with hand-derived expectations (state after the edge)
   typedef struct {
      logic          s, f, b;
      logic [31:0]   tgt;
      logic [AW-1:0] addr;
      logic          valid;
      logic [31:0]   pc, instr, cnt;
      logic          mis;
   } vec_t;

   localparam int NV = 21;
   vec_t vt [NV];

   task automatic setv(input int i, input logic s, input logic f, input logic b,
                       input logic [31:0] tgt, input int addr, input logic v,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input int cnt, input logic mis);
      vt[i].s = s; vt[i].f = f; vt[i].b = b; vt[i].tgt = tgt;
      vt[i].addr = AW'(addr); vt[i].valid = v; vt[i].pc = pc;
      vt[i].instr = instr; vt[i].cnt = 32'(cnt); vt[i].mis = mis;
   endtask

   initial begin
      for (int k = 0; k < int'(DEPTH); k++) rom[k] = (32'(k) << 7) | 32'h13;

      //       i  s f b  target       addr  v  pc           instr         cnt mis
      setv( 0, 0,0,0, 32'h0,        0,  0, 32'h0,       32'h13,        0, 0); // BOOT edge
      setv( 1, 0,0,0, 32'h0,        1,  1, 32'h0,       32'h13,        1, 0); // first valid
      setv( 2, 0,0,0, 32'h0,        2,  1, 32'h4,       32'h93,        2, 0);
      setv( 3, 0,0,0, 32'h0,        3,  1, 32'h8,       32'h113,       3, 0);
      setv( 4, 1,0,0, 32'h0,        3,  1, 32'h8,       32'h113,       3, 0); // stall x3
      setv( 5, 1,0,0, 32'h0,        3,  1, 32'h8,       32'h113,       3, 0);
      setv( 6, 1,0,0, 32'h0,        3,  1, 32'h8,       32'h113,       3, 0);
      setv( 7, 0,0,0, 32'h0,        4,  1, 32'hC,       32'h193,       4, 0); // release
      setv( 8, 0,0,1, 32'h40,      16,  0, 32'h10,      32'h13,        4, 0); // branch
      setv( 9, 0,0,0, 32'h0,       17,  1, 32'h40,      32'h813,       5, 0);
      setv(10, 1,0,1, 32'h80,      32,  0, 32'h44,      32'h13,        5, 0); // branch+stall
      setv(11, 0,0,0, 32'h0,       33,  1, 32'h80,      32'h1013,      6, 0);
      setv(12, 0,0,1, 32'h42,      16,  0, 32'h84,      32'h13,        6, 1); // misaligned
      setv(13, 0,0,0, 32'h0,       17,  1, 32'h40,      32'h813,       7, 1);
      setv(14, 0,0,1, 32'h100,     64,  0, 32'h44,      32'h13,        7, 1); // aligned, sticky
      setv(15, 0,1,0, 32'h0,       65,  0, 32'h100,     32'h13,        7, 1); // flush
      setv(16, 0,0,0, 32'h0,       66,  1, 32'h104,     32'h2093,      8, 1);
      setv(17, 1,1,0, 32'h0,       66,  0, 32'h108,     32'h13,        8, 1); // flush+stall
      setv(18, 0,0,0, 32'h0,       67,  1, 32'h108,     32'h2113,      9, 1);
      setv(19, 0,0,1, 32'h1000,     0,  0, 32'h10C,     32'h13,        9, 1); // ROM alias
      setv(20, 0,0,0, 32'h0,        1,  1, 32'h1000,    32'h13,       10, 1);

      RESET = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      branch_target = 32'd0;
      model_reset();
      repeat (2) @(negedge CLK);
      check_reset_vals("reset");
      RESET = 1'b0;

      for (int i = 0; i < NV; i++) begin
         logic [31:0] ei;
         string tag;
         step(vt[i].s, vt[i].f, vt[i].b, vt[i].tgt);
         tag = $sformatf("vec%0d", i);
         ei  = vt[i].instr;
         chk({tag, ".addr"},   32'(seen_addr), 32'(vt[i].addr));
         chk({tag, ".valid"},  32'(if_id_valid), 32'(vt[i].valid));
         chk({tag, ".pc"},     if_id_pc, vt[i].pc);
         chk({tag, ".instr"},  if_id_instruction, vt[i].instr);
         chk({tag, ".opcode"}, 32'(if_id_opcode), 32'(ei[6:0]));
         chk({tag, ".count"},  fetch_count, vt[i].cnt);
         chk({tag, ".mis"},    32'(misalign_err), 32'(vt[i].mis));
      end

      // Asynchronous reset in the middle of a stall, away from any clock edge
      step(1'b1, 1'b0, 1'b0, 32'd0);
      stall = 1'b1;
      #2 RESET = 1'b1;
      #1 check_reset_vals("midreset");
      @(negedge CLK);
      RESET = 1'b0; stall = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check_model("reboot0");
      chk("reboot0.valid_const", 32'(if_id_valid), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check_model("reboot1");
      chk("reboot1.pc_const", if_id_pc, RST_PC);
      chk("reboot1.count_const", fetch_count, 32'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic s, f, b;
         logic [31:0] t;
         s = ($urandom_range(3) == 0);
         f = ($urandom_range(9) == 0);
         b = ($urandom_range(7) == 0);
         t = $urandom;
         if ($urandom_range(3) != 0) t[1:0] = 2'b00;
         step(s, f, b, t);
         check_model($sformatf("rand%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
